// File: rtl/fully_connected_param.sv
// Time-multiplexed FP32 fully-connected layer: one multiplier and one adder walk
// every neuron serially, accumulating bias first and then products in input order.

module FP_Top_Mult (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_valid,
  output logic [31:0] o_result
);
  logic [47:0] w_prod;
  logic [23:0] w_mant;
  logic [24:0] w_mant_r;
  logic [22:0] w_frac;
  logic [9:0]  w_exp;
  logic        w_rnd, w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [31:0] w_res;

  // Round-to-nearest-even; subnormal inputs and results flush to zero.
  always_comb begin
    w_sign   = i_a[31] ^ i_b[31];
    w_a_zero = (i_a[30:23] == 8'd0);
    w_b_zero = (i_b[30:23] == 8'd0);
    w_a_inf  = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
    w_b_inf  = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
    w_a_nan  = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
    w_b_nan  = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
    w_prod   = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});
    if (w_prod[47]) begin
      w_mant = w_prod[47:24];
      w_rnd  = w_prod[23] & ((|w_prod[22:0]) | w_prod[24]);
    end else begin
      w_mant = w_prod[46:23];
      w_rnd  = w_prod[22] & ((|w_prod[21:0]) | w_prod[23]);
    end
    w_mant_r = {1'b0, w_mant} + {24'd0, w_rnd};
    w_frac   = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];
    w_exp    = {2'b00, i_a[30:23]} + {2'b00, i_b[30:23]} - 10'd127
             + {9'd0, w_prod[47]} + {9'd0, w_mant_r[24]};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_res = 32'h7FC00000;
    else if (w_a_inf || w_b_inf)
      w_res = {w_sign, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_zero)
      w_res = {w_sign, 31'd0};
    else if ($signed(w_exp) >= 10'sd255)
      w_res = {w_sign, 8'hFF, 23'd0};
    else if ($signed(w_exp) <= 10'sd0)
      w_res = {w_sign, 31'd0};
    else
      w_res = {w_sign, w_exp[7:0], w_frac};
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_result <= 32'd0;
    end else begin
      o_valid  <= i_valid;
      o_result <= w_res;
    end
  end
endmodule

module FP_Top_AddSub (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_sub,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_valid,
  output logic [31:0] o_result
);
  logic [31:0] w_b, w_x, w_y, w_res;
  logic [26:0] w_mx, w_my, w_al, w_n;
  logic [53:0] w_sh;
  logic [27:0] w_sum;
  logic [24:0] w_m;
  logic [22:0] w_frac;
  logic [9:0]  w_e, w_ef;
  logic [7:0]  w_d;
  logic [4:0]  w_dcl, w_lz;
  logic        w_eff_sub, w_rnd;

  // x is the larger magnitude; y is aligned with guard/round/sticky bits.
  always_comb begin
    w_b = {i_b[31] ^ i_sub, i_b[30:0]};
    if (w_b[30:0] > i_a[30:0]) begin
      w_x = w_b;
      w_y = i_a;
    end else begin
      w_x = i_a;
      w_y = w_b;
    end
    w_mx  = (w_x[30:23] == 8'd0) ? 27'd0 : {1'b1, w_x[22:0], 3'b000};
    w_my  = (w_y[30:23] == 8'd0) ? 27'd0 : {1'b1, w_y[22:0], 3'b000};
    w_d   = w_x[30:23] - w_y[30:23];
    w_dcl = (w_d > 8'd27) ? 5'd27 : w_d[4:0];
    w_sh  = {w_my, 27'd0} >> w_dcl;
    w_al  = {w_sh[53:28], w_sh[27] | (|w_sh[26:0])};
    w_eff_sub = w_x[31] ^ w_y[31];
    w_sum = w_eff_sub ? ({1'b0, w_mx} - {1'b0, w_al}) : ({1'b0, w_mx} + {1'b0, w_al});
    w_lz = 5'd0;
    for (int k = 0; k < 27; k++)
      if (w_sum[k]) w_lz = 5'(26 - k);
    if (w_sum[27]) begin
      w_n = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e = {2'b00, w_x[30:23]} + 10'd1;
    end else begin
      w_n = w_sum[26:0] << w_lz;
      w_e = {2'b00, w_x[30:23]} - {5'd0, w_lz};
    end
    w_rnd  = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_m    = {1'b0, w_n[26:3]} + {24'd0, w_rnd};
    w_frac = w_m[24] ? w_m[23:1] : w_m[22:0];
    w_ef   = w_e + {9'd0, w_m[24]};
    if (w_x[30:23] == 8'hFF) begin
      if ((w_x[22:0] != 23'd0) || ((w_y[30:23] == 8'hFF) && w_eff_sub))
        w_res = 32'h7FC00000;
      else
        w_res = {w_x[31], 8'hFF, 23'd0};
    end else if (w_sum == 28'd0)
      w_res = {w_x[31] & w_y[31], 31'd0};
    else if ($signed(w_ef) >= 10'sd255)
      w_res = {w_x[31], 8'hFF, 23'd0};
    else if ($signed(w_ef) <= 10'sd0)
      w_res = {w_x[31], 31'd0};
    else
      w_res = {w_x[31], w_ef[7:0], w_frac};
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_result <= 32'd0;
    end else begin
      o_valid  <= i_valid;
      o_result <= w_res;
    end
  end
endmodule

module fully_connected_param #(
  parameter int NUM_IN  = 16,
  parameter int NUM_OUT = 4,
  parameter int RELU    = 0,
  parameter int ADDR_W  = (NUM_OUT * (NUM_IN + 1) > 1) ? $clog2(NUM_OUT * (NUM_IN + 1)) : 1,
  parameter int OIDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_weight,
  input  logic [31:0]       weight,
  output logic              load_weight_done,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [31:0]       data_in,
  output logic [31:0]       feature,
  output logic              valid_out,
  output logic [OIDX_W-1:0] out_index,
  output logic              frame_done,
  output logic              busy
);
  localparam int XW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int DEPTH  = NUM_OUT * (NUM_IN + 1);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [XW-1:0]     X_LAST = XW'(NUM_IN - 1);
  localparam logic [OIDX_W-1:0] N_LAST = OIDX_W'(NUM_OUT - 1);

  // IDLE/LOAD_X collect inputs; INIT..WAIT_A run one MAC at a time; OUT presents a neuron.
  typedef enum logic [2:0] {IDLE, LOAD_X, INIT, MUL, WAIT_M, ADD, WAIT_A, OUT} state_t;
  state_t r_state, w_next;

  logic [31:0]       r_mem  [0:DEPTH-1];
  logic [31:0]       r_xbuf [0:NUM_IN-1];
  logic [ADDR_W-1:0] r_wcnt, w_base, w_waddr, w_baddr;
  logic [XW-1:0]     r_xcnt, r_i;
  logic [OIDX_W-1:0] r_n, r_oidx;
  logic [31:0]       r_acc, r_prod, r_feature, w_relu, w_mul_res, w_add_res;
  logic              r_wdone, w_w_acc, w_x_acc, w_mul_v, w_add_v;

  assign w_base  = ADDR_W'(NUM_IN + 1) * ADDR_W'(r_n);
  assign w_waddr = w_base + ADDR_W'(r_i);
  assign w_baddr = w_base + ADDR_W'(NUM_IN);
  assign w_relu  = ((RELU != 0) && r_acc[31]) ? 32'd0 : r_acc;

  assign ready_in         = r_wdone && ((r_state == IDLE) || (r_state == LOAD_X));
  assign busy             = (r_state != IDLE) && (r_state != LOAD_X);
  assign load_weight_done = r_wdone;
  assign valid_out        = (r_state == OUT);
  assign frame_done       = (r_state == OUT) && (r_n == N_LAST);
  assign feature          = (r_state == OUT) ? w_relu : r_feature;
  assign out_index        = (r_state == OUT) ? r_n : r_oidx;
  assign w_w_acc          = load_weight && (r_state == IDLE) && (r_xcnt == '0);
  assign w_x_acc          = valid_in && ready_in;

  FP_Top_Mult u_mult (
    .clk(clk), .i_rst_n(~resetn), .i_valid(r_state == MUL),
    .i_a(r_xbuf[r_i]), .i_b(r_mem[w_waddr]), .o_valid(w_mul_v), .o_result(w_mul_res)
  );

  FP_Top_AddSub u_add (
    .clk(clk), .i_rst_n(~resetn), .i_valid(r_state == ADD), .i_sub(1'b0),
    .i_a(r_acc), .i_b(r_prod), .o_valid(w_add_v), .o_result(w_add_res)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_x_acc) w_next = (r_xcnt == X_LAST) ? INIT : LOAD_X;
      LOAD_X:  if (w_x_acc && (r_xcnt == X_LAST)) w_next = INIT;
      INIT:    w_next = MUL;
      MUL:     w_next = WAIT_M;
      WAIT_M:  if (w_mul_v) w_next = ADD;
      ADD:     w_next = WAIT_A;
      WAIT_A:  if (w_add_v) w_next = (r_i == X_LAST) ? OUT : MUL;
      OUT:     w_next = (r_n == N_LAST) ? IDLE : INIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_w_acc) r_mem[r_wcnt] <= weight;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_wdone   <= 1'b0;
      r_xcnt    <= '0;
      r_i       <= '0;
      r_n       <= '0;
      r_oidx    <= '0;
      r_acc     <= 32'd0;
      r_prod    <= 32'd0;
      r_feature <= 32'd0;
      for (int k = 0; k < NUM_IN; k++) r_xbuf[k] <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_w_acc) begin
        r_wcnt <= (r_wcnt == W_LAST) ? '0 : r_wcnt + 1'b1;
        if (r_wcnt == W_LAST) r_wdone <= 1'b1;
      end
      if (w_x_acc) begin
        r_xbuf[r_xcnt] <= data_in;
        r_xcnt <= (r_xcnt == X_LAST) ? '0 : r_xcnt + 1'b1;
      end
      case (r_state)
        INIT: begin
          r_acc <= r_mem[w_baddr];
          r_i   <= '0;
        end
        WAIT_M: if (w_mul_v) r_prod <= w_mul_res;
        WAIT_A: if (w_add_v) begin
          r_acc <= w_add_res;
          if (r_i != X_LAST) r_i <= r_i + 1'b1;
        end
        OUT: begin
          r_feature <= w_relu;
          r_oidx    <= r_n;
          r_n       <= (r_n == N_LAST) ? '0 : r_n + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fully_connected_param.sv
// Directed bench for fully_connected_param: a plain and a ReLU instance share one
// stimulus stream; expected neuron outputs are queued and popped on valid_out.

module tb_fully_connected_param;
  logic        clk = 1'b0;
  logic        resetn, load_weight, valid_in;
  logic [31:0] weight, data_in;
  logic        ldone0, ready0, valid0, fdone0, busy0, idx0;
  logic        ldone1, ready1, valid1, fdone1, busy1, idx1;
  logic [31:0] feat0, feat1;

  typedef struct {
    logic [31:0] f;
    logic [31:0] fr;
    logic        idx;
    logic        fd;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fully_connected_param #(.NUM_IN(4), .NUM_OUT(2), .RELU(0)) dut (
    .clk(clk), .resetn(resetn), .load_weight(load_weight), .weight(weight),
    .load_weight_done(ldone0), .valid_in(valid_in), .ready_in(ready0), .data_in(data_in),
    .feature(feat0), .valid_out(valid0), .out_index(idx0), .frame_done(fdone0), .busy(busy0)
  );

  fully_connected_param #(.NUM_IN(4), .NUM_OUT(2), .RELU(1)) dut_relu (
    .clk(clk), .resetn(resetn), .load_weight(load_weight), .weight(weight),
    .load_weight_done(ldone1), .valid_in(valid_in), .ready_in(ready1), .data_in(data_in),
    .feature(feat1), .valid_out(valid1), .out_index(idx1), .frame_done(fdone1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid0 === 1'b1 || valid1 === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid_out", 32'(valid0 | valid1), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("feature", feat0, e.f);
        check("feature_relu", feat1, e.fr);
        check("out_index", 32'(idx0), 32'(e.idx));
        check("out_index_relu", 32'(idx1), 32'(e.idx));
        check("frame_done", 32'(fdone0), 32'(e.fd));
        check("valid_out_relu", 32'(valid1), 32'd1);
        check("frame_done_relu", 32'(fdone1), 32'(e.fd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v);
    valid_in = 1'b1;
    data_in  = v;
    tick();
    valid_in = 1'b0;
    data_in  = 32'd0;
  endtask

  task automatic load_w(input logic [31:0] v);
    load_weight = 1'b1;
    weight      = v;
    tick();
    load_weight = 1'b0;
    weight      = 32'd0;
  endtask

  task automatic load_all();
    for (int k = 0; k < 4; k++) load_w(32'h3F800000);
    load_w(32'h3F000000);
    for (int k = 0; k < 4; k++) load_w(32'hBF800000);
    load_w(32'h00000000);
    check("load_weight_done", 32'(ldone0), 32'd1);
    check("load_weight_done_relu", 32'(ldone1), 32'd1);
    check("ready_after_load", 32'(ready0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_feature"}, feat0 | feat1, 32'd0);
    check({tag, "_valid"}, 32'({valid0, valid1, fdone0, fdone1}), 32'd0);
    check({tag, "_index"}, 32'({idx0, idx1}), 32'd0);
    check({tag, "_busy"}, 32'({busy0, busy1}), 32'd0);
    check({tag, "_ready"}, 32'({ready0, ready1}), 32'd0);
    check({tag, "_ldone"}, 32'({ldone0, ldone1}), 32'd0);
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (fdone0 === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      check("frame_timeout", 32'(fdone0), 32'd1);
    end else begin
      check("ready_low_at_frame_done", 32'(ready0), 32'd0);
      tick();
      check("ready_after_frame", 32'({ready0, ready1}), 32'b11);
      check("queue_drained", q.size(), 32'd0);
    end
  endtask

  task automatic run_frame(input logic [31:0] x0, input logic [31:0] x1,
                           input logic [31:0] x2, input logic [31:0] x3,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e1r, input bit ljunk);
    q.push_back('{e0, e0, 1'b0, 1'b0});
    q.push_back('{e1, e1r, 1'b1, 1'b1});
    send(x0);
    if (ljunk) begin
      check("ready_in_load_x", 32'(ready0), 32'd1);
      load_w(32'h4479C000);
    end
    send(x1);
    send(x2);
    send(x3);
    for (int k = 0; k < 3; k++) begin
      check("busy_during_compute", 32'({busy0, busy1}), 32'b11);
      check("ready_low_busy", 32'({ready0, ready1}), 32'd0);
      send(32'h7F7FFFFF);
    end
  endtask

  initial begin
    resetn = 1'b1;
    load_weight = 1'b0;
    weight = 32'd0;
    valid_in = 1'b0;
    data_in = 32'd0;
    repeat (3) tick();
    check_reset_outputs("reset");
    resetn = 1'b0;
    tick();

    for (int k = 0; k < 3; k++) begin
      check("ready_before_weights", 32'(ready0), 32'd0);
      send(32'h40000000);
    end
    repeat (3) tick();
    check("busy_before_weights", 32'(busy0), 32'd0);

    load_all();
    run_frame(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h41280000, 32'hC1200000, 32'h00000000, 1'b0);
    wait_frame();

    run_frame(32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
              32'h41A40000, 32'hC1A00000, 32'h00000000, 1'b1);
    wait_frame();

    run_frame(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h41280000, 32'hC1200000, 32'h00000000, 1'b0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
        @(negedge clk);
        if (valid0 === 1'b1 && idx0 === 1'b0) seen = 1'b1;
      end
      if (!seen) check("neuron0_timeout", 32'(valid0), 32'd1);
    end
    repeat (5) @(posedge clk);
    #1;
    check("busy_before_abort", 32'(busy0), 32'd1);
    resetn = 1'b1;
    q.delete();
    #1;
    check_reset_outputs("abort");
    tick();
    check_reset_outputs("abort_next");
    resetn = 1'b0;
    tick();

    load_all();
    run_frame(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h41280000, 32'hC1200000, 32'h00000000, 1'b0);
    wait_frame();
    repeat (5) tick();
    check("final_queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
